mul_div_unit: RTL

- Multi-cycle, WIDTH-parametrised signed multiply/divide unit for the CPU datapath.
- Replaces the single-cycle MUL/DIV paths in the datapath ALU; all other ALU operations remain combinational.
- Multiply uses radix-4 Booth (bit-pair recoding) at one partial product per clock; divide uses non-restoring division at one quotient bit per clock.
- The control unit drives it with a start/busy/done handshake; the 2*WIDTH result is written to the HI/LO registers.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mul_div_unit_booth.sv | 16 +
 rtl/mul_div_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types, opcode constants and helpers for the multiply/divide unit.
package mdu_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  // Opcodes decoded by the control unit to select this unit
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;

  // Widest operand abs_w() can handle; callers sign-extend into it
  localparam int MAX_W = 64;

  // Two's-complement magnitude; the most-negative value maps to itself,
  // which reads correctly as an unsigned magnitude once truncated
  function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] x);
    return x[MAX_W-1] ? -x : x;
  endfunction

endpackage

// File: rtl/mul_div_unit_booth.sv
// Radix-4 Booth digit recoder: {b[2k+1], b[2k], b[2k-1]} -> digit controls.
module booth_r4_recode (
  input  logic [2:0] window,
  output logic       neg,
  output logic       zero,
  output logic       two
);

  // Digit in {-2,-1,0,+1,+2}: sign, zero and magnitude-two flags
  always_comb begin
    neg  = window[2];
    zero = (window == 3'b000) || (window == 3'b111);
    two  = (window == 3'b011) || (window == 3'b100);
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (radix-4 Booth) / divide (non-restoring) unit.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op_mul,
  input  logic             op_div,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] Chigh,
  output logic [WIDTH-1:0] Clow
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int W2    = 2 * WIDTH;

  state_t             state;
  logic [CNT_W-1:0]   k;
  logic [W2-1:0]      mcand;
  logic [W2-1:0]      acc;
  logic [WIDTH:0]     mplier;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   dmag;
  logic               sign_a;
  logic               sign_b;

  logic               neg;
  logic               zero;
  logic               two;
  logic [W2-1:0]      pp;
  logic [W2-1:0]      acc_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_next;
  logic [WIDTH-1:0]   quot_next;
  logic [WIDTH-1:0]   rem_pos;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   quot_fix;

  booth_r4_recode u_recode (
    .window (mplier[2:0]),
    .neg    (neg),
    .zero   (zero),
    .two    (two)
  );

  // Booth step: add or subtract 0, 1x or 2x the (pre-shifted) multiplicand
  always_comb begin
    pp = two ? (mcand << 1) : mcand;
    if (zero) pp = '0;
    acc_next = neg ? (acc - pp) : (acc + pp);
  end

  // Non-restoring step: shift in next dividend bit, add/sub by remainder sign
  always_comb begin
    rem_sh    = {rem[WIDTH-1:0], quot[WIDTH-1]};
    rem_next  = rem[WIDTH] ? (rem_sh + {1'b0, dmag}) : (rem_sh - {1'b0, dmag});
    quot_next = {quot[WIDTH-2:0], ~rem_next[WIDTH]};
  end

  // Final correction: restore remainder, then apply truncating-division signs
  always_comb begin
    rem_pos  = rem[WIDTH] ? (rem[WIDTH-1:0] + dmag) : rem[WIDTH-1:0];
    rem_fix  = sign_a ? -rem_pos : rem_pos;
    quot_fix = (sign_a ^ sign_b) ? -quot : quot;
  end

  // Sequencer and all datapath registers
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state       <= IDLE;
      k           <= '0;
      mcand       <= '0;
      acc         <= '0;
      mplier      <= '0;
      rem         <= '0;
      quot        <= '0;
      dmag        <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      Chigh       <= '0;
      Clow        <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && (op_mul || op_div)) begin
            busy  <= 1'b1;
            k     <= '0;
            // mcand also keeps A for the divide-by-zero result
            mcand <= W2'(signed'(A));
            if (op_mul) begin
              mplier <= {B, 1'b0};
              acc    <= '0;
              state  <= MUL;
            end else begin
              quot   <= WIDTH'(abs_w(MAX_W'(signed'(A))));
              dmag   <= WIDTH'(abs_w(MAX_W'(signed'(B))));
              rem    <= '0;
              sign_a <= A[WIDTH-1];
              sign_b <= B[WIDTH-1];
              state  <= DIV;
            end
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 2;
          mplier <= mplier >> 2;
          k      <= k + 1'b1;
          if (k == CNT_W'(WIDTH / 2 - 1)) begin
            Chigh       <= acc_next[W2-1:WIDTH];
            Clow        <= acc_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        DIV: begin
          if (dmag == '0) begin
            Chigh       <= mcand[WIDTH-1:0];
            Clow        <= '1;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            rem  <= rem_next;
            quot <= quot_next;
            k    <= k + 1'b1;
            if (k == CNT_W'(WIDTH - 1)) state <= FIX;
          end
        end
        FIX: begin
          Chigh       <= rem_fix;
          Clow        <= quot_fix;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
